mips_trace_uart: RTL and testbench
==================================

Name: mips_trace_uart

Overview:
- Retirement-trace streamer, directly downstream of the single-cycle MIPS computer.
- Consumes per-instruction outputs: New_clk, PC_Out, ALU_Result, AND_Output (branch taken).
- Captures one snapshot per retired instruction and serializes it as a 10-byte frame on a UART 8N1 line for board-level debug.
- One-entry pending buffer decouples the instruction rate from the UART; retirements arriving while the buffer is full are dropped and flagged.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, same clk that drives the computer
rst  input  1  asynchronous, active-high reset
new_clk  input  1  computer's New_clk; synchronous to clk; rising edge = one instruction retired
pc_in  input  32  PC_Out of the retiring instruction
alu_in  input  32  ALU_Result of the retiring instruction
br_taken  input  1  AND_Output (branch select) of the retiring instruction
ovf_clr  input  1  one-cycle pulse; clears overflow
tx  output  1  UART serial out, idle high
busy  output  1  high while a frame is transmitting or pending is valid
overflow  output  1  sticky drop flag
frame_count  output  16  frames fully sent, wraps 16'hFFFF -> 0

Behaviour:
Reset (asynchronous, rst=1):
- tx=1, busy=0, overflow=0, frame_count=0.
- Pending valid=0; state=IDLE.
- new_clk edge register forced to 1, so a high new_clk at reset release does not produce a spurious retire.

Retire detect:
- ret = new_clk & ~new_clk_q, where new_clk_q is new_clk registered on clk.
- No synchronizer: new_clk is clk-synchronous.

Capture, on a cycle D with ret=1:
- If pending empty, or the transmitter loads pending in the same cycle: {pc_in, alu_in, br_taken} registers into pending at end of D; pending valid=1.
- Otherwise: the snapshot is dropped and overflow=1 from D+1.

Overflow:
- ovf_clr clears overflow.
- If ovf_clr and a drop occur in the same cycle, overflow stays 1 (set wins).

Transmitter FSM, states IDLE, START, DATA, STOP:
- IDLE:
  - If pending valid: load frame from pending, clear pending valid, byte index=0, go START.
  - Load occurs at D+1 for a capture in D; tx falls at D+2.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte index<9: increment index, go START; no inter-byte gap.
  - If byte index=9: frame_count+1 on the last STOP cycle, go IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts at each bit boundary.

Frame byte order:
- byte 0: SYNC_BYTE
- bytes 1-4: pc[31:24], pc[23:16], pc[15:8], pc[7:0]
- bytes 5-8: alu[31:24] .. alu[7:0]
- byte 9: {7'b0, br_taken}

Timing and status:
- Frame length = 100*CLKS_PER_BIT cycles.
- Back-to-back frames: IDLE lasts exactly 1 cycle between the last stop bit and the next start bit.
- busy = (state!=IDLE) | pending valid; registered, so it follows state and pending with zero extra lag.

Reset mid-frame:
- tx returns high immediately.
- The partial frame is discarded and not counted.

Test Plan (CLKS_PER_BIT=4):
1. Single retire: pc_in=32'h0000_0004, alu_in=32'h0000_0011, br_taken=0, one new_clk rising edge -> tx low exactly 2 cycles after the detect cycle. Decoded bytes A5 00 00 00 04 00 00 00 11 00. frame_count=1 after 400 cycles. busy falls the cycle after the last stop bit.
2. Two retires 50 cycles apart -> first frame sent; second held in pending and sent after 1 IDLE cycle with its own values. overflow=0; frame_count=2.
3. Three retires within 100 cycles -> frames 1 and 2 sent, third dropped. overflow=1 from the cycle after the third edge; frame_count ends at 2.
4. ovf_clr pulsed in the same cycle as a drop -> overflow stays 1. ovf_clr alone the next cycle -> overflow=0.
5. Assert rst during byte 4 of a frame -> tx=1, busy=0, frame_count unchanged from pre-frame value. With new_clk held high through reset release, no frame is sent until the next true rising edge.
6. Wrap: preload 65535 frames (or force frame_count=16'hFFFF), send one frame with br_taken=1, pc=32'hDEAD_BEEF -> byte 9=01, bytes 1-4=DE AD BE EF, frame_count=0.

Source files
------------

// File: rtl/mips_trace_uart.sv
// Retirement-trace streamer: one 10-byte UART 8N1 frame per retired MIPS instruction.
// Latency: tx start bit begins 2 clk after the retire-detect cycle; frame = 100*CLKS_PER_BIT clk.
// Backpressure: none upstream; one pending snapshot, further retirements dropped and flagged in overflow.
module mips_trace_uart #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_clk,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_in,
    input  logic        br_taken,
    input  logic        ovf_clr,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam int             BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           new_clk_q;
    logic           ret;
    logic           load;
    logic           bit_end;
    logic           pend_vld;
    logic [31:0]    pend_pc;
    logic [31:0]    pend_alu;
    logic           pend_br;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [3:0]     byte_idx;
    logic [7:0]     byte_sr;
    logic [71:0]    frame_sr;

    assign ret     = new_clk & ~new_clk_q;
    assign load    = (state == IDLE) & pend_vld;
    assign bit_end = (baud == BAUD_MAX);
    // state and pend_vld are both registers, so busy tracks them with no extra lag
    assign busy    = (state != IDLE) | pend_vld;

    // Edge register; reset to 1 so a high new_clk at reset release is not a retirement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) new_clk_q <= 1'b1;
        else     new_clk_q <= new_clk;
    end

    // One-entry pending buffer and sticky drop flag (a drop beats a same-cycle clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_pc  <= '0;
            pend_alu <= '0;
            pend_br  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ret && (!pend_vld || load)) begin
                pend_vld <= 1'b1;
                pend_pc  <= pc_in;
                pend_alu <= alu_in;
                pend_br  <= br_taken;
            end else if (load) begin
                pend_vld <= 1'b0;
            end
            if (ret && pend_vld && !load) overflow <= 1'b1;
            else if (ovf_clr)             overflow <= 1'b0;
        end
    end

    // Transmitter: bytes go out back to back; one IDLE cycle separates consecutive frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tx          <= 1'b1;
            baud        <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            byte_sr     <= '0;
            frame_sr    <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (pend_vld) begin
                        byte_sr  <= SYNC_BYTE;
                        frame_sr <= {pend_pc, pend_alu, 7'b0, pend_br};
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        tx      <= byte_sr[0];
                        byte_sr <= {1'b0, byte_sr[7:1]};
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx      <= byte_sr[0];
                            byte_sr <= {1'b0, byte_sr[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (byte_idx == 4'd9) begin
                            frame_count <= frame_count + 1'b1;
                            state       <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            byte_sr  <= frame_sr[71:64];
                            frame_sr <= {frame_sr[63:0], 8'h00};
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_trace_uart.sv
// Directed bench for mips_trace_uart with CLKS_PER_BIT=4.
// Outputs sampled on the falling clock edge; inputs driven on the falling edge.
// Serial frames decoded by sampling each bit mid-period.
module tb_mips_trace_uart;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_clk;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic        br_taken;
    logic        ovf_clr;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mips_trace_uart #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .new_clk(new_clk), .pc_in(pc_in), .alu_in(alu_in),
        .br_taken(br_taken), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
        .overflow(overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One retirement: new_clk high for one cycle starting at this falling edge
    task automatic retire(input logic [31:0] pc, input logic [31:0] alu, input logic br);
        pc_in    = pc;
        alu_in   = alu;
        br_taken = br;
        new_clk  = 1'b1;
        @(negedge clk);
        new_clk  = 1'b0;
    endtask

    // Called at a falling edge; waits for the start bit, returns at mid stop bit
    task automatic rx_byte(output logic [7:0] b);
        int n;
        n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            check("rx_start_timeout", 80'(n), 80'(0));
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", 80'(tx), 80'(1));
    endtask

    task automatic rx_frame(output logic [79:0] f);
        logic [7:0] b;
        f = '0;
        for (int k = 0; k < 10; k++) begin
            rx_byte(b);
            f = {f[71:0], b};
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 80'(busy), 80'(0));
    endtask

    logic [79:0] f1, f2;
    int          t0;

    initial begin
        rst = 1'b1; new_clk = 1'b0; pc_in = '0; alu_in = '0; br_taken = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 80'(tx), 80'(1));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_ovf", 80'(overflow), 80'(0));
        check("rst_fc", 80'(frame_count), 80'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single retire, start-bit latency and frame timing
        retire(32'h0000_0004, 32'h0000_0011, 1'b0);
        check("t1_tx_d1", 80'(tx), 80'(1));
        check("t1_busy_d1", 80'(busy), 80'(1));
        @(negedge clk);
        check("t1_tx_d2", 80'(tx), 80'(0));
        t0 = cyc;
        rx_frame(f1);
        check("t1_frame", f1, 80'hA5_00000004_00000011_00);
        @(negedge clk);
        check("t1_busy_last_stop", 80'(busy), 80'(1));
        @(negedge clk);
        check("t1_busy_after", 80'(busy), 80'(0));
        check("t1_frame_len", 80'(cyc - t0), 80'(100 * CPB));
        check("t1_fc", 80'(frame_count), 80'(1));

        // 2: second retire held in pending, one IDLE cycle between frames
        fork
            begin
                retire(32'h0000_0100, 32'hAAAA_5555, 1'b0);
                repeat (49) @(negedge clk);
                retire(32'h0000_0104, 32'h1234_5678, 1'b1);
            end
            begin
                rx_frame(f1);
                @(negedge clk);
                @(negedge clk);
                check("t2_gap_tx", 80'(tx), 80'(1));
                check("t2_gap_busy", 80'(busy), 80'(1));
                @(negedge clk);
                check("t2_b2b_start", 80'(tx), 80'(0));
                rx_frame(f2);
            end
        join
        check("t2_frame1", f1, 80'hA5_00000100_AAAA5555_00);
        check("t2_frame2", f2, 80'hA5_00000104_12345678_01);
        repeat (2) @(negedge clk);
        check("t2_ovf", 80'(overflow), 80'(0));
        check("t2_fc", 80'(frame_count), 80'(3));

        // 3: third retire within one frame time is dropped
        fork
            begin
                retire(32'h0000_0200, 32'h0000_0001, 1'b0);
                repeat (9) @(negedge clk);
                retire(32'h0000_0204, 32'h0000_0002, 1'b0);
                repeat (9) @(negedge clk);
                check("t3_ovf_before", 80'(overflow), 80'(0));
                retire(32'h0000_0208, 32'h0000_0003, 1'b1);
                check("t3_ovf_set", 80'(overflow), 80'(1));
            end
            begin
                rx_frame(f1);
                rx_frame(f2);
            end
        join
        check("t3_frame1", f1, 80'hA5_00000200_00000001_00);
        check("t3_frame2", f2, 80'hA5_00000204_00000002_00);
        repeat (50) @(negedge clk);
        check("t3_no_third", 80'(busy), 80'(0));
        check("t3_fc", 80'(frame_count), 80'(5));
        check("t3_ovf_sticky", 80'(overflow), 80'(1));

        // 4: clear, then clear coinciding with a drop
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_clr", 80'(overflow), 80'(0));
        fork
            begin
                retire(32'h0000_0300, 32'h0000_00AA, 1'b0);
                repeat (9) @(negedge clk);
                retire(32'h0000_0304, 32'h0000_00BB, 1'b1);
                repeat (9) @(negedge clk);
                pc_in = 32'h0000_0308; new_clk = 1'b1; ovf_clr = 1'b1;
                @(negedge clk);
                new_clk = 1'b0; ovf_clr = 1'b0;
                check("t4_set_wins", 80'(overflow), 80'(1));
                ovf_clr = 1'b1;
                @(negedge clk);
                ovf_clr = 1'b0;
                check("t4_clr_alone", 80'(overflow), 80'(0));
            end
            begin
                rx_frame(f1);
                rx_frame(f2);
            end
        join
        check("t4_frame2", f2, 80'hA5_00000304_000000BB_01);
        wait_idle();
        check("t4_fc", 80'(frame_count), 80'(7));

        // 6: frame counter wrap
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        check("t6_preload", 80'(frame_count), 80'(16'hFFFF));
        retire(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        rx_frame(f1);
        check("t6_frame", f1, 80'hA5_DEADBEEF_0BADF00D_01);
        repeat (2) @(negedge clk);
        check("t6_wrap", 80'(frame_count), 80'(0));

        // 5: reset mid-frame, new_clk held high through release
        retire(32'h0000_0400, 32'h0000_0044, 1'b0);
        repeat (4 * 10 * CPB + 5) @(negedge clk);
        check("t5_busy_mid", 80'(busy), 80'(1));
        rst = 1'b1;
        new_clk = 1'b1;
        #1;
        check("t5_rst_tx", 80'(tx), 80'(1));
        check("t5_rst_busy", 80'(busy), 80'(0));
        check("t5_rst_fc", 80'(frame_count), 80'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_no_spurious_busy", 80'(busy), 80'(0));
        check("t5_no_spurious_tx", 80'(tx), 80'(1));
        new_clk = 1'b0;
        @(negedge clk);
        retire(32'h0000_0500, 32'h0000_0055, 1'b1);
        rx_frame(f1);
        check("t5_frame", f1, 80'hA5_00000500_00000055_01);
        repeat (2) @(negedge clk);
        check("t5_fc", 80'(frame_count), 80'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
